// File: rtl/laser_pkg.sv
// laser_pkg: shared definitions for the LASER circle-placement engine and its checkers.
//   OBJ_NUM    points per pattern
//   RADIUS_SQ  coverage threshold on squared Euclidean distance (radius 4)
//   CNT_W      width of a 0..OBJ_NUM count
//   point_t    packed {y, x} point, 4 bits per coordinate
//   state_e    laser_score sequencing states
package laser_pkg;

  localparam int unsigned OBJ_NUM   = 40;
  localparam int unsigned RADIUS_SQ = 16;
  localparam int unsigned CNT_W     = $clog2(OBJ_NUM + 1);

  typedef struct packed {
    logic [3:0] y;
    logic [3:0] x;
  } point_t;

  typedef enum logic [1:0] {
    StIdle,
    StScore,
    StReport
  } state_e;

endpackage

// File: rtl/laser_cover_check.sv
// laser_cover_check: combinational coverage test of one point against one circle centre.
//   pt       point under test {y, x}
//   ctr      circle centre {y, x}
//   covered  1 when dx^2 + dy^2 <= RADIUS_SQ
module laser_cover_check
  import laser_pkg::*;
#(
  parameter int unsigned RADIUS_SQ = laser_pkg::RADIUS_SQ
) (
  input  point_t pt,
  input  point_t ctr,
  output logic   covered
);

  logic [3:0] dx;
  logic [3:0] dy;
  logic [8:0] dist_sq;

  always_comb begin
    dx = (pt.x >= ctr.x) ? (pt.x - ctr.x) : (ctr.x - pt.x);
    dy = (pt.y >= ctr.y) ? (pt.y - ctr.y) : (ctr.y - pt.y);
    // 15^2 + 15^2 = 450 still fits in 9 bits, so no overflow is possible.
    dist_sq = (9'(dx) * 9'(dx)) + (9'(dy) * 9'(dy));
    covered = (dist_sq <= 9'(RADIUS_SQ));
  end

endmodule

// File: rtl/laser_score.sv
// laser_score: downstream checker for LASER. Snoops the point stream into a capture buffer,
// and on an accepted DONE copies it to a score buffer, latches both centres and scores one
// point per cycle against both circles.
//   CLK, RST     clock; asynchronous active-high reset
//   IN_VALID     X/Y carry a valid point this cycle
//   X, Y         point coordinates
//   DONE         LASER result strobe; C1X..C2Y valid in the same cycle
//   C1X..C2Y     circle centres reported by LASER
//   BUSY         scoring in progress
//   SCORE_VALID  one-cycle pulse qualifying SCORE, C1_CNT, C2_CNT and ERR
//   SCORE        points covered by either circle (union, counted per point)
//   C1_CNT       points covered by circle 1
//   C2_CNT       points covered by circle 2
//   ERR          DONE arrived without a complete pattern
module laser_score #(
  parameter int unsigned OBJ_NUM   = laser_pkg::OBJ_NUM,
  parameter int unsigned RADIUS_SQ = laser_pkg::RADIUS_SQ
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           IN_VALID,
  input  logic [3:0]                     X,
  input  logic [3:0]                     Y,
  input  logic                           DONE,
  input  logic [3:0]                     C1X,
  input  logic [3:0]                     C1Y,
  input  logic [3:0]                     C2X,
  input  logic [3:0]                     C2Y,
  output logic                           BUSY,
  output logic                           SCORE_VALID,
  output logic [$clog2(OBJ_NUM+1)-1:0]   SCORE,
  output logic [$clog2(OBJ_NUM+1)-1:0]   C1_CNT,
  output logic [$clog2(OBJ_NUM+1)-1:0]   C2_CNT,
  output logic                           ERR
);

  import laser_pkg::point_t;
  import laser_pkg::state_e;
  import laser_pkg::StIdle;
  import laser_pkg::StScore;
  import laser_pkg::StReport;

  localparam int unsigned CntW = $clog2(OBJ_NUM + 1);
  localparam int unsigned IdxW = $clog2(OBJ_NUM);

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   fill_q, fill_d;
  logic [CntW-1:0]   acc_u_q, acc_u_d;
  logic [CntW-1:0]   acc_1_q, acc_1_d;
  logic [CntW-1:0]   acc_2_q, acc_2_d;

  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   score_q, score_d;
  logic [CntW-1:0]   c1_cnt_q, c1_cnt_d;
  logic [CntW-1:0]   c2_cnt_q, c2_cnt_d;

  point_t            cap_buf_q   [OBJ_NUM];
  point_t            score_buf_q [OBJ_NUM];
  point_t            c1_q;
  point_t            c2_q;

  // ---------------------------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------------------------
  logic            busy;
  logic            full;
  logic            accept;
  logic            reject;
  logic            last;
  logic            wr_en;
  logic [IdxW-1:0] wr_idx;
  point_t          in_pt;
  point_t          cur_pt;
  logic            cov1;
  logic            cov2;

  always_comb begin
    busy   = (state_q == StScore);
    full   = (fill_q == CntW'(OBJ_NUM));
    // REPORT counts as not busy so DONE can be taken at the minimum 41-cycle spacing.
    accept = DONE && !busy && full;
    reject = DONE && !busy && !full;
    last   = (idx_q == IdxW'(OBJ_NUM - 1));
    in_pt  = '{y: Y, x: X};
    cur_pt = score_buf_q[idx_q];
  end

  // ---------------------------------------------------------------------------------------------
  // Coverage tests against both latched centres
  // ---------------------------------------------------------------------------------------------
  laser_cover_check #(
    .RADIUS_SQ (RADIUS_SQ)
  ) u_cover_c1 (
    .pt      (cur_pt),
    .ctr     (c1_q),
    .covered (cov1)
  );

  laser_cover_check #(
    .RADIUS_SQ (RADIUS_SQ)
  ) u_cover_c2 (
    .pt      (cur_pt),
    .ctr     (c2_q),
    .covered (cov2)
  );

  // ---------------------------------------------------------------------------------------------
  // Capture fill logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    fill_d = fill_q;
    wr_en  = 1'b0;
    wr_idx = fill_q[IdxW-1:0];
    if (accept || reject) begin
      // A point arriving with DONE starts the next pattern at entry 0.
      fill_d = '0;
      wr_idx = '0;
      if (IN_VALID) begin
        wr_en  = 1'b1;
        fill_d = CntW'(1);
      end
    end else if (IN_VALID && !full) begin
      wr_en  = 1'b1;
      fill_d = fill_q + CntW'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM next-state, accumulators and registered outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_u_d  = acc_u_q;
    acc_1_d  = acc_1_q;
    acc_2_d  = acc_2_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    score_d  = score_q;
    c1_cnt_d = c1_cnt_q;
    c2_cnt_d = c2_cnt_q;

    unique case (state_q)
      StIdle, StReport: begin
        state_d = StIdle;
        if (accept) begin
          state_d = StScore;
          idx_d   = '0;
          acc_u_d = '0;
          acc_1_d = '0;
          acc_2_d = '0;
        end
      end
      StScore: begin
        acc_u_d = acc_u_q + CntW'(cov1 | cov2);
        acc_1_d = acc_1_q + CntW'(cov1);
        acc_2_d = acc_2_q + CntW'(cov2);
        idx_d   = idx_q + IdxW'(1);
        if (last) begin
          state_d  = StReport;
          valid_d  = 1'b1;
          err_d    = 1'b0;
          score_d  = acc_u_d;
          c1_cnt_d = acc_1_d;
          c2_cnt_d = acc_2_d;
        end
      end
      default: state_d = StIdle;
    endcase

    if (reject) begin
      valid_d  = 1'b1;
      err_d    = 1'b1;
      score_d  = '0;
      c1_cnt_d = '0;
      c2_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      fill_q   <= '0;
      acc_u_q  <= '0;
      acc_1_q  <= '0;
      acc_2_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      score_q  <= '0;
      c1_cnt_q <= '0;
      c2_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fill_q   <= fill_d;
      acc_u_q  <= acc_u_d;
      acc_1_q  <= acc_1_d;
      acc_2_q  <= acc_2_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      score_q  <= score_d;
      c1_cnt_q <= c1_cnt_d;
      c2_cnt_q <= c2_cnt_d;
    end
  end

  // Buffer contents need no reset: fill and the FSM gate every use of them.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      cap_buf_q[wr_idx] <= in_pt;
    end
    if (accept) begin
      score_buf_q <= cap_buf_q;
      c1_q        <= '{y: C1Y, x: C1X};
      c2_q        <= '{y: C2Y, x: C2X};
    end
  end

  assign BUSY        = busy;
  assign SCORE_VALID = valid_q;
  assign ERR         = err_q;
  assign SCORE       = score_q;
  assign C1_CNT      = c1_cnt_q;
  assign C2_CNT      = c2_cnt_q;

endmodule

// File: tb/tb_laser_score.sv
// tb_laser_score: directed self-checking bench for laser_score.
module tb_laser_score;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic [3:0] X, Y;
  logic       DONE;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       BUSY;
  logic       SCORE_VALID;
  logic [5:0] SCORE, C1_CNT, C2_CNT;
  logic       ERR;

  int checks = 0;
  int errors = 0;

  laser_score #(
    .OBJ_NUM   (40),
    .RADIUS_SQ (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_VALID    (IN_VALID),
    .X           (X),
    .Y           (Y),
    .DONE        (DONE),
    .C1X         (C1X),
    .C1Y         (C1Y),
    .C2X         (C2X),
    .C2Y         (C2Y),
    .BUSY        (BUSY),
    .SCORE_VALID (SCORE_VALID),
    .SCORE       (SCORE),
    .C1_CNT      (C1_CNT),
    .C2_CNT      (C2_CNT),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int n, input logic [3:0] px, input logic [3:0] py);
    repeat (n) begin
      IN_VALID = 1'b1;
      X        = px;
      Y        = py;
      tick();
    end
    IN_VALID = 1'b0;
  endtask

  task automatic done_pulse(input logic [3:0] ax, input logic [3:0] ay,
                            input logic [3:0] bx, input logic [3:0] by);
    DONE = 1'b1;
    C1X  = ax;
    C1Y  = ay;
    C2X  = bx;
    C2Y  = by;
    tick();
    DONE = 1'b0;
  endtask

  // Called right after the DONE edge; expects the report 40 edges later.
  task automatic expect_score(input string tag, input int s, input int n1, input int n2);
    int n;
    check({tag, "_busy_start"}, 32'(BUSY), 32'd1);
    check({tag, "_novalid_start"}, 32'(SCORE_VALID), 32'd0);
    n = 0;
    while (SCORE_VALID !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd40);
    check({tag, "_score"}, 32'(SCORE), 32'(s));
    check({tag, "_c1"}, 32'(C1_CNT), 32'(n1));
    check({tag, "_c2"}, 32'(C2_CNT), 32'(n2));
    check({tag, "_err"}, 32'(ERR), 32'd0);
    check({tag, "_busy_report"}, 32'(BUSY), 32'd0);
    tick();
    check({tag, "_pulse_one_cycle"}, 32'(SCORE_VALID), 32'd0);
    check({tag, "_hold"}, 32'(SCORE), 32'(s));
  endtask

  initial begin
    bit saw_valid;

    RST = 1'b1; IN_VALID = 1'b0; X = '0; Y = '0; DONE = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_valid", 32'(SCORE_VALID), 32'd0);
    check("rst_score", 32'(SCORE), 32'd0);
    check("rst_c1", 32'(C1_CNT), 32'd0);
    check("rst_c2", 32'(C2_CNT), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);

    // All points on C1.
    load(40, 4'd5, 4'd5);
    done_pulse(4'd5, 4'd5, 4'd0, 4'd0);
    expect_score("all_c1", 40, 40, 0);

    // Boundary: (10,11) d2=13 in, (11,11) d2=18 out, (8,12) d2=16 in, (9,12) d2=17 out.
    load(1, 4'd10, 4'd11);
    load(1, 4'd11, 4'd11);
    load(1, 4'd8, 4'd12);
    load(1, 4'd9, 4'd12);
    load(36, 4'd0, 4'd0);
    done_pulse(4'd8, 4'd8, 4'd0, 4'd0);
    expect_score("boundary", 38, 2, 36);

    // Identical centres: union counted once per point.
    load(40, 4'd3, 4'd3);
    done_pulse(4'd3, 4'd3, 4'd3, 4'd3);
    expect_score("same_ctr", 40, 40, 40);

    // Short pattern.
    load(39, 4'd1, 4'd1);
    done_pulse(4'd1, 4'd1, 4'd0, 4'd0);
    check("short_valid", 32'(SCORE_VALID), 32'd1);
    check("short_err", 32'(ERR), 32'd1);
    check("short_score", 32'(SCORE), 32'd0);
    check("short_c1", 32'(C1_CNT), 32'd0);
    check("short_c2", 32'(C2_CNT), 32'd0);
    check("short_busy", 32'(BUSY), 32'd0);
    tick();
    check("short_pulse_one_cycle", 32'(SCORE_VALID), 32'd0);
    // (2,6) to C1=(2,2): d2=16 in; (12,12) on C2.
    load(20, 4'd2, 4'd6);
    load(20, 4'd12, 4'd12);
    done_pulse(4'd2, 4'd2, 4'd12, 4'd12);
    expect_score("after_short", 40, 20, 20);

    // Back-to-back. A: (6,4) in C1=(6,6); (15,0) in C2=(12,0); (0,15) in neither.
    load(20, 4'd6, 4'd4);
    load(15, 4'd15, 4'd0);
    load(5, 4'd0, 4'd15);
    // B point 0 arrives with A's DONE.
    IN_VALID = 1'b1; X = 4'd15; Y = 4'd15;
    done_pulse(4'd6, 4'd6, 4'd12, 4'd0);
    check("b2b_busy_start", 32'(BUSY), 32'd1);
    // B: 0..14 at (15,15), 15..29 at (1,2), 30..39 at (7,7); stray DONE at i==20.
    for (int i = 1; i < 40; i++) begin
      IN_VALID = 1'b1;
      if (i < 15) begin
        X = 4'd15; Y = 4'd15;
      end else if (i < 30) begin
        X = 4'd1; Y = 4'd2;
      end else begin
        X = 4'd7; Y = 4'd7;
      end
      DONE = (i == 20);
      tick();
      check("b2b_novalid", 32'(SCORE_VALID), 32'd0);
      check("b2b_busy", 32'(BUSY), 32'd1);
    end
    IN_VALID = 1'b0;
    DONE     = 1'b0;
    tick();
    check("b2b_a_valid", 32'(SCORE_VALID), 32'd1);
    check("b2b_a_score", 32'(SCORE), 32'd35);
    check("b2b_a_c1", 32'(C1_CNT), 32'd20);
    check("b2b_a_c2", 32'(C2_CNT), 32'd15);
    check("b2b_a_err", 32'(ERR), 32'd0);
    // B's DONE exactly 41 cycles after A's.
    done_pulse(4'd15, 4'd15, 4'd0, 4'd0);
    expect_score("b2b_b", 30, 15, 15);

    // Reset in the middle of scoring.
    load(40, 4'd9, 4'd9);
    done_pulse(4'd9, 4'd9, 4'd0, 4'd0);
    repeat (19) tick();
    check("mid_busy_before", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_valid", 32'(SCORE_VALID), 32'd0);
    check("mid_rst_score", 32'(SCORE), 32'd0);
    check("mid_rst_c1", 32'(C1_CNT), 32'd0);
    check("mid_rst_c2", 32'(C2_CNT), 32'd0);
    check("mid_rst_err", 32'(ERR), 32'd0);
    tick();
    tick();
    RST = 1'b0;
    saw_valid = 1'b0;
    repeat (50) begin
      tick();
      if (SCORE_VALID === 1'b1 || BUSY === 1'b1) saw_valid = 1'b1;
    end
    check("mid_rst_no_pulse", 32'(saw_valid), 32'd0);
    // Fresh: (4,4) on C1; (13,9) to C2=(13,13) d2=16 in; (9,9) in neither.
    load(10, 4'd4, 4'd4);
    load(25, 4'd13, 4'd9);
    load(5, 4'd9, 4'd9);
    done_pulse(4'd4, 4'd4, 4'd13, 4'd13);
    expect_score("post_rst", 35, 10, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
